load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory port. Accepts one sized load or store per transaction from the core's MEM stage. It drives the 64-bit big-endian `Memory` interface (combinational read, synchronous 8-byte write) and returns sign- or zero-extended load data. Sub-doubleword stores use read-modify-write so that neighbouring bytes are preserved.

## Interface
Parameters:
- ADDR_W, 64, byte-address width (matches `endereco`)

Ports:
- One clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (size/sign)
- req_addr  in  ADDR_W  byte address A
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_error  out  1  illegal funct3, qualified by resp_valid
- resp_rdata  out  64  extended load data
- mem_read  out  1  to memory
- mem_write  out  1  to memory, sampled at posedge
- mem_endereco  out  ADDR_W  memory address
- mem_write_data  out  64  memory write data
- mem_read_data  in  64  combinational read data; byte A is in [63:56]

## Operation
- Access size by funct3:
  - 000 B, 100 BU: 1 byte
  - 001 H, 101 HU: 2 bytes
  - 010 W, 110 WU: 4 bytes
  - 011 D: 8 bytes
- Legal store funct3 values are 000–011 only. 111 on a load, or ≥100 on a store, is illegal.
- Byte order is big-endian: the value occupies bytes A..A+n-1, with byte A most significant.
- Load extraction uses mem_read_data[63:64-8n]. It is sign-extended (B/H/W) or zero-extended (BU/HU/WU); D is passed unchanged.
- Store merge takes req_wdata[8n-1:0] into mem_write_data[63:64-8n]. The low 64-8n bits come from the captured read data.
- No alignment check; unaligned A is legal. The caller keeps A+7 inside the physical array.
- Request fields are registered on acceptance (req_valid & req_ready at posedge).
- FSM states and transitions:
  - IDLE: req_ready=1. Illegal → RESP(error). Load or sub-D store → RD. SD → WR.
  - RD: mem_read=1, mem_endereco=A. Captures mem_read_data at the posedge. Load → RESP; store → WR.
  - WR: mem_write=1, mem_endereco=A, mem_write_data = merged data or full wdata. → RESP.
  - RESP: resp_valid=1 → IDLE.
- resp_rdata is registered. It takes the extended value for loads and 0 for stores and errors, and holds until the next RESP.
- mem_read, mem_write and req_ready are decoded from the state register only.
- mem_endereco and mem_write_data are 0 outside RD/WR.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_read=0, mem_write=0, mem_endereco=0, mem_write_data=0.
- Latency is counted from the accept edge (edge 0) to the cycle in which resp_valid is high:
  - load: 2
  - SD: 2
  - SB/SH/SW: 3
  - illegal: 1
- Throughput: the next request can be accepted in the cycle after RESP (IDLE). req_ready is low in RD/WR/RESP, so requests presented then are ignored.
- No response backpressure: resp_valid is a single-cycle pulse.
- Reset asserted mid-transaction (including WR):
  - state → IDLE immediately and mem_write drops without waiting for a clock.
  - A write edge coinciding with reset is not issued.
  - No response is produced for the aborted request.
- Exactly one mem_write edge per store; loads never assert mem_write.

## Structure
- lsu_pkg holds:
  - funct3 constants (F3_B … F3_WU)
  - the state encoding (IDLE, RD, WR, RESP)
  - a size-in-bytes function
- Sub-module lsu_align is purely combinational. It takes funct3 and the 64-bit read data and produces extended load data and the merged store word. The FSM stays in load_store_unit.

## Test plan
- Preload bytes 40..47 = 80 C0 A0 90 88 84 82 81.
- LB @40 → resp_rdata=FFFF_FFFF_FFFF_FF80 in cycle 2, mem_read high in cycle 1 only. LBU @40 → 0x80.
- LH @40 → FFFF_FFFF_FFFF_80C0; LHU → 0x80C0; LWU @40 → 0x80C0_A090; LD @40 → 80C0_A090_8884_8281.
- SB wdata=0x12 @41 → RD in cycle 1, WR in cycle 2 with data 12A0_9088_8482_81xx (byte 48 preserved), resp in cycle 3. A following LD @40 returns 8012_A090_8884_8281.
- SD 0x0102_0304_0506_0708 @0 → no mem_read, single WR in cycle 1, resp in cycle 2. Bytes 0..7 = 01..08.
- Load funct3=111 and store funct3=100 → resp_valid & resp_error in cycle 1, resp_rdata=0, mem_read and mem_write never asserted.
- rst_n low during the WR cycle → mem_write falls asynchronously and memory is unchanged. After release, req_ready=1 and no resp_valid occurs.

Source files
------------

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RISC-V funct3 encodings for loads/stores (size and signedness)
//   - FSM state encoding used by load_store_unit
//   - size_bytes(): access width in bytes for a funct3 value
//   - is_illegal(): funct3 legality for a load or a store
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Access width in bytes; bits [1:0] of funct3 select the size for
    // both signed and unsigned variants.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // Stores only have B/H/W/D; loads have everything except 111.
    function automatic logic is_illegal(input logic write, input logic [2:0] funct3);
        return write ? funct3[2] : (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if
// Bundles the core-side request/response handshake and the data-memory
// port of the load/store unit.
//   slave  : the load_store_unit side (accepts requests, drives memory)
//   master : the environment side (core MEM stage + memory model)
// Signals:
//   req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata : request
//   resp_valid/resp_error/resp_rdata                            : response
//   mem_read/mem_write/mem_endereco/mem_write_data/mem_read_data: memory
// ---------------------------------------------------------------------------
interface lsu_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;

    logic              resp_valid;
    logic              resp_error;
    logic [63:0]       resp_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_endereco;
    logic [63:0]       mem_write_data;
    logic [63:0]       mem_read_data;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready,
        output resp_valid, resp_error, resp_rdata,
        output mem_read, mem_write, mem_endereco, mem_write_data
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready,
        input  resp_valid, resp_error, resp_rdata,
        input  mem_read, mem_write, mem_endereco, mem_write_data
    );

endinterface

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational data alignment for a big-endian 64-bit memory word
// whose most significant byte [63:56] is the byte at the access address.
// Ports:
//   funct3     in  3   access size/sign
//   rdata      in  64  memory word read at the access address
//   wdata      in  64  store data, right-justified
//   load_data  out 64  sign/zero-extended load value
//   store_data out 64  store bytes in the top of the word, remaining low
//                      bytes taken from rdata (read-modify-write merge)
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [63:0] rdata,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] store_data
);

    // NOTE: every output of an always_comb is given a default first so no
    // path through the case statements can infer a latch.
    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{56{rdata[63]}}, rdata[63:56]};
            F3_BU:   load_data = {56'd0, rdata[63:56]};
            F3_H:    load_data = {{48{rdata[63]}}, rdata[63:48]};
            F3_HU:   load_data = {48'd0, rdata[63:48]};
            F3_W:    load_data = {{32{rdata[63]}}, rdata[63:32]};
            F3_WU:   load_data = {32'd0, rdata[63:32]};
            F3_D:    load_data = rdata;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        store_data = wdata;
        case (size_bytes(funct3))
            4'd1:    store_data = {wdata[7:0],  rdata[55:0]};
            4'd2:    store_data = {wdata[15:0], rdata[47:0]};
            4'd4:    store_data = {wdata[31:0], rdata[31:0]};
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Initiator side of the data-memory port. Accepts one sized load or store
// per transaction, drives a 64-bit big-endian memory (combinational read,
// synchronous 8-byte write) and returns extended load data. Sub-doubleword
// stores read the word first and merge so neighbouring bytes survive.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    lsu_if.slave: request/response handshake and memory port
// Flow: IDLE -> (RD) -> (WR) -> RESP -> IDLE; illegal funct3 goes straight
// to RESP with resp_error set.
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);

    state_t            state_q, state_d;

    logic              write_q;
    logic              err_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [63:0]       rdata_q;
    logic [63:0]       resp_rdata_q;

    logic              accept;
    logic              req_illegal;
    logic [63:0]       align_rdata;
    logic [63:0]       load_data;
    logic [63:0]       store_data;

    assign accept      = (state_q == ST_IDLE) && bus.req_valid;
    assign req_illegal = is_illegal(bus.req_write, bus.req_funct3);

    // Loads extend the live read data at the RD edge; the store merge in WR
    // uses the copy captured at that same edge.
    assign align_rdata = (state_q == ST_RD) ? bus.mem_read_data : rdata_q;

    lsu_align u_align (
        .funct3     (f3_q),
        .rdata      (align_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (req_illegal) begin
                        state_d = ST_RESP;
                    end else if (bus.req_write && (bus.req_funct3 == F3_D)) begin
                        state_d = ST_WR;       // full doubleword: no read needed
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:   state_d = write_q ? ST_WR : ST_RESP;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- request capture and response data ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_rdata_q <= '0;
        end else begin
            if (accept) begin
                write_q <= bus.req_write;
                err_q   <= req_illegal;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                if (req_illegal) begin
                    resp_rdata_q <= '0;
                end
            end
            if (state_q == ST_RD) begin
                rdata_q <= bus.mem_read_data;
                if (!write_q) begin
                    resp_rdata_q <= load_data;
                end
            end
            if (state_q == ST_WR) begin
                resp_rdata_q <= '0;
            end
        end
    end

    // ---------------- outputs (decoded from the state register) ----------------
    assign bus.req_ready      = (state_q == ST_IDLE);
    assign bus.mem_read       = (state_q == ST_RD);
    assign bus.mem_write      = (state_q == ST_WR);
    assign bus.resp_valid     = (state_q == ST_RESP);
    assign bus.resp_error     = (state_q == ST_RESP) && err_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.mem_endereco   = ((state_q == ST_RD) || (state_q == ST_WR)) ? addr_q : '0;
    assign bus.mem_write_data = (state_q == ST_WR) ? store_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Drives load_store_unit through lsu_if against a byte-array memory and
// compares every transaction with a byte-level reference model.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic load_mem = 1'b0;

    always #5 clk = ~clk;

    lsu_if #(.ADDR_W(64)) bus ();

    load_store_unit #(.ADDR_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [7:0] tb_mem  [256];   // memory seen by the DUT
    logic [7:0] ref_mem [256];   // reference byte image

    int n_checks = 0;
    int n_pass   = 0;

    // Combinational big-endian read: byte at mem_endereco lands in [63:56].
    always_comb begin
        bus.mem_read_data = '0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_read_data[63-8*i -: 8] = tb_mem[8'(bus.mem_endereco[7:0] + 8'(i))];
        end
    end

    // Synchronous 8-byte write; load_mem copies the reference image in.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= ref_mem[i];
        end else if (bus.mem_write) begin
            for (int i = 0; i < 8; i++) begin
                tb_mem[8'(bus.mem_endereco[7:0] + 8'(i))] <= bus.mem_write_data[63-8*i -: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic illegal(input logic wr, input logic [2:0] f3);
        return wr ? (f3 >= 3'd4) : (f3 == 3'd7);
    endfunction

    function automatic logic [63:0] ref_load(input int addr, input logic [2:0] f3);
        logic [63:0] v = '0;
        int n = nbytes(f3);
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[addr + i]);
        if (f3 < 3'd3 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    // Word the memory should receive: new bytes at A.., old bytes after.
    function automatic logic [63:0] ref_word(input int addr, input logic [2:0] f3,
                                             input logic [63:0] wd);
        logic [63:0] w = '0;
        int n = nbytes(f3);
        for (int i = 0; i < 8; i++) begin
            if (i < n) w = (w << 8) | 64'((wd >> (8*(n-1-i))) & 64'hFF);
            else       w = (w << 8) | 64'(ref_mem[addr + i]);
        end
        return w;
    endfunction

    task automatic ref_store(input int addr, input logic [2:0] f3, input logic [63:0] wd);
        int n = nbytes(f3);
        for (int i = 0; i < n; i++) ref_mem[addr + i] = 8'((wd >> (8*(n-1-i))) & 64'hFF);
    endtask

    // ---------------- one transaction ----------------
    task automatic run_req(input logic wr, input logic [2:0] f3, input int addr,
                           input logic [63:0] wd, output logic [63:0] got);
        logic        ill   = illegal(wr, f3);
        int          e_lat, e_rd, e_wr;
        logic [63:0] e_rdata, e_wdata;
        int          lat = 0, nrd = 0, nwr = 0, rd_c = 0, wr_c = 0, busy_ready = 0;

        e_lat   = ill ? 1 : (!wr ? 2 : (f3 == 3'd3 ? 2 : 3));
        e_rd    = (ill || (wr && f3 == 3'd3)) ? 0 : 1;
        e_wr    = (wr && !ill) ? 1 : 0;
        e_rdata = (ill || wr) ? 64'd0 : ref_load(addr, f3);
        e_wdata = ref_word(addr, f3, wd);
        got     = '0;

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = 64'(addr);
        bus.req_wdata  = wd;
        @(posedge clk);                      // accept edge (edge 0)
        for (int c = 1; c <= 6; c++) begin
            #1;
            if (bus.req_ready) busy_ready++;
            if (bus.mem_read) begin
                nrd++;
                rd_c = c;
                check("rd_addr", bus.mem_endereco, 64'(addr));
            end
            if (bus.mem_write) begin
                nwr++;
                wr_c = c;
                check("wr_addr", bus.mem_endereco, 64'(addr));
                check("wr_data", bus.mem_write_data, e_wdata);
            end
            if (!bus.mem_read && !bus.mem_write)
                check("bus_zero", bus.mem_endereco | bus.mem_write_data, 64'd0);
            if (bus.resp_valid) begin
                lat = c;
                got = bus.resp_rdata;
                check("resp_error", 64'(bus.resp_error), 64'(ill));
                check("resp_rdata", bus.resp_rdata, e_rdata);
                bus.req_valid = 1'b0;
                break;
            end
            @(posedge clk);
        end
        bus.req_valid = 1'b0;
        check("latency", 64'(lat), 64'(e_lat));
        check("n_read", 64'(nrd), 64'(e_rd));
        check("n_write", 64'(nwr), 64'(e_wr));
        check("rd_cycle", 64'(rd_c), 64'(e_rd));
        check("wr_cycle", 64'(wr_c), e_wr != 0 ? 64'(e_lat - 1) : 64'd0);
        check("ready_busy", 64'(busy_ready), 64'd0);

        @(posedge clk);
        #1;
        check("resp_pulse", 64'(bus.resp_valid), 64'd0);
        check("ready_idle", 64'(bus.req_ready), 64'd1);
        check("rdata_hold", bus.resp_rdata, e_rdata);

        if (wr && !ill) ref_store(addr, f3, wd);
    endtask

    // ---------------- stimulus ----------------
    logic [63:0] got;
    logic [63:0] wd;
    logic [63:0] mem_word;
    int          mism;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        ref_mem[40] = 8'h80; ref_mem[41] = 8'hC0; ref_mem[42] = 8'hA0; ref_mem[43] = 8'h90;
        ref_mem[44] = 8'h88; ref_mem[45] = 8'h84; ref_mem[46] = 8'h82; ref_mem[47] = 8'h81;

        load_mem = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        load_mem = 1'b0;

        // Reset values
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_error", 64'(bus.resp_error), 64'd0);
        check("rst_resp_rdata", bus.resp_rdata, 64'd0);
        check("rst_mem_rw", {62'd0, bus.mem_read, bus.mem_write}, 64'd0);
        check("rst_mem_addr", bus.mem_endereco, 64'd0);
        check("rst_mem_wdata", bus.mem_write_data, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Directed loads on the preloaded bytes
        run_req(1'b0, 3'b000, 40, 64'd0, got); check("LB_const",  got, 64'hFFFF_FFFF_FFFF_FF80);
        run_req(1'b0, 3'b100, 40, 64'd0, got); check("LBU_const", got, 64'h0000_0000_0000_0080);
        run_req(1'b0, 3'b001, 40, 64'd0, got); check("LH_const",  got, 64'hFFFF_FFFF_FFFF_80C0);
        run_req(1'b0, 3'b101, 40, 64'd0, got); check("LHU_const", got, 64'h0000_0000_0000_80C0);
        run_req(1'b0, 3'b110, 40, 64'd0, got); check("LWU_const", got, 64'h0000_0000_80C0_A090);
        run_req(1'b0, 3'b011, 40, 64'd0, got); check("LD_const",  got, 64'h80C0_A090_8884_8281);

        // Byte store preserves neighbours; upper wdata bits must be ignored
        run_req(1'b1, 3'b000, 41, 64'hDEAD_BEEF_CAFE_0012, got);
        run_req(1'b0, 3'b011, 40, 64'd0, got); check("SB_LD_const", got, 64'h8012_A090_8884_8281);

        // Doubleword store without a read
        run_req(1'b1, 3'b011, 0, 64'h0102_0304_0506_0708, got);
        run_req(1'b0, 3'b011, 0, 64'd0, got); check("SD_LD_const", got, 64'h0102_0304_0506_0708);

        // Illegal funct3
        run_req(1'b0, 3'b111, 40, 64'd0, got);
        run_req(1'b1, 3'b100, 40, 64'hFFFF_FFFF_FFFF_FFFF, got);

        // Reset asserted during the WR cycle of a byte store
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 64'd100;
        bus.req_wdata  = ~64'(ref_mem[100]);
        @(posedge clk);                      // edge 0 -> RD
        @(posedge clk);                      // edge 1 -> WR
        #1;
        check("rst_wr_before", 64'(bus.mem_write), 64'd1);
        #2;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("rst_wr_async", 64'(bus.mem_write), 64'd0);
        check("rst_wr_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check("rst_no_resp", 64'(bus.resp_valid), 64'd0);
            check("rst_ready_after", 64'(bus.req_ready), 64'd1);
        end
        mem_word = '0;
        for (int i = 0; i < 8; i++) mem_word = (mem_word << 8) | 64'(tb_mem[100 + i]);
        check("rst_mem_intact", mem_word, ref_word(100, 3'b011, 64'd0) & 64'd0 |
              {ref_mem[100], ref_mem[101], ref_mem[102], ref_mem[103],
               ref_mem[104], ref_mem[105], ref_mem[106], ref_mem[107]});

        // Randomized mix including unaligned and illegal requests
        for (int t = 0; t < 60; t++) begin
            wd = {$urandom, $urandom};
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    int'($urandom_range(0, 200)), wd, got);
        end

        // Whole memory image matches the reference
        mism = 0;
        for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
        check("mem_image", 64'(mism), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
